offload_arbiter: RTL and testbench

//  Shares one offloaded accelerator (e.g. the k-means distance unit) among NUM_REQ

---
 rtl/offload_pkg.sv | 34 +++
 rtl/offload_arbiter_if.sv | 33 +++
 rtl/offload_tag_fifo.sv | 46 ++++
 rtl/offload_arbiter.sv | 115 +++++++++++
 tb/tb_offload_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/offload_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the offload arbiter.
package offload_pkg;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_REQ_W           = 64;
  localparam int DEF_RESP_W          = 32;
  localparam int DEF_MAX_OUTSTANDING = 4;

  localparam int CNT_W = $clog2(DEF_MAX_OUTSTANDING) + 1;
  localparam int PTR_W = $clog2(DEF_MAX_OUTSTANDING);

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

  // First valid requester at or after ptr, wrapping at num (num in 2..16).
  // Returns ptr unchanged when nothing is valid; callers qualify with |valid.
  function automatic logic [3:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input int          num);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = (int'(ptr) + k) % num;
      if (!found && (k < num) && valid[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/offload_arbiter_if.sv
// Engine-side and accelerator-side handshake bundle for the offload arbiter.
interface offload_arbiter_if #(
  parameter int NUM_REQ = offload_pkg::DEF_NUM_REQ,
  parameter int REQ_W   = offload_pkg::DEF_REQ_W,
  parameter int RESP_W  = offload_pkg::DEF_RESP_W
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*REQ_W-1:0] req_data;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [RESP_W-1:0]        resp_data;
  logic                     off_req_valid;
  logic                     off_req_ready;
  logic [REQ_W-1:0]         off_req_data;
  logic                     off_resp_valid;
  logic                     off_resp_ready;
  logic [RESP_W-1:0]        off_resp_data;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, resp_ready, off_req_ready, off_resp_valid, off_resp_data,
    output req_ready, resp_valid, resp_data, off_req_valid, off_req_data, off_resp_ready
  );

  // Engines plus accelerator side.
  modport master (
    output req_valid, req_data, resp_ready, off_req_ready, off_resp_valid, off_resp_data,
    input  req_ready, resp_valid, resp_data, off_req_valid, off_req_data, off_resp_ready
  );

endinterface

// File: rtl/offload_tag_fifo.sv
// Small FIFO of requester ids, one entry per in-flight accelerator request.
// Pointers carry one extra wrap bit so equal indices distinguish full from empty.
module offload_tag_fifo
  import offload_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage write; contents need no reset since the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer advance; push and pop together are legal while non-empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head id and empty flag are read straight from the registered state.
  always_comb begin
    head  = mem[rd_ptr[AW-1:0]];
    empty = (wr_ptr == rd_ptr);
  end

endmodule

// File: rtl/offload_arbiter.sv
// Round-robin arbiter sharing one in-order accelerator among NUM_REQ engines,
// bounding in-flight work and steering each response back to its requester.
module offload_arbiter
  import offload_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int REQ_W           = DEF_REQ_W,
  parameter int RESP_W          = DEF_RESP_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                               clk,
  input  logic                               reset_n,
  offload_arbiter_if.slave                   bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_orphan
);

  localparam int ID_BITS  = $clog2(NUM_REQ);
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING) + 1;

  logic                live_reg;
  logic                lock_reg;
  logic [ID_BITS-1:0]  grant_reg;
  logic [ID_BITS-1:0]  rr_ptr_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic                err_reg;

  logic [ID_BITS-1:0]  pick;
  logic [ID_BITS-1:0]  grant;
  logic [ID_BITS-1:0]  head;
  logic                empty;
  logic                can_issue;
  logic                issue;
  logic                ret;
  logic                orphan;

  // Outputs stay quiet until the first clock after reset release (sync deassert).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live_reg <= 1'b0;
    else          live_reg <= 1'b1;
  end

  // Issue side: round-robin pick, held grant while the accelerator stalls.
  always_comb begin
    pick              = ID_BITS'(rr_pick(16'(bus.req_valid), 4'(rr_ptr_reg), NUM_REQ));
    grant             = lock_reg ? grant_reg : pick;
    can_issue         = live_reg && (cnt_reg < CNT_BITS'(MAX_OUTSTANDING));
    bus.off_req_valid = can_issue && (lock_reg || (|bus.req_valid));
    bus.off_req_data  = bus.req_data[int'(grant)*REQ_W +: REQ_W];
    issue             = bus.off_req_valid && bus.off_req_ready;
    bus.req_ready     = '0;
    if (issue) bus.req_ready[grant] = 1'b1;
  end

  // Return side: head tag steers the response; an empty FIFO swallows orphans.
  always_comb begin
    bus.resp_data      = bus.off_resp_data;
    bus.resp_valid     = '0;
    if (live_reg && bus.off_resp_valid && !empty) bus.resp_valid[head] = 1'b1;
    bus.off_resp_ready = live_reg && (empty ? bus.off_resp_valid : bus.resp_ready[head]);
    ret                = bus.off_resp_valid && bus.off_resp_ready && !empty;
    orphan             = live_reg && bus.off_resp_valid && empty;
  end

  // Round-robin pointer and grant lock; the lock pins off_req_data during a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
      lock_reg   <= 1'b0;
      grant_reg  <= '0;
    end else if (issue) begin
      rr_ptr_reg <= (grant == ID_BITS'(NUM_REQ - 1)) ? '0 : grant + ID_BITS'(1);
      lock_reg   <= 1'b0;
    end else if (bus.off_req_valid) begin
      lock_reg   <= 1'b1;
      grant_reg  <= grant;
    end
  end

  // In-flight count; simultaneous issue and return cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      case ({issue, ret})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Sticky orphan-response flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    err_reg <= 1'b0;
    else if (orphan) err_reg <= 1'b1;
  end

  offload_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_BITS)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (issue),
    .push_data (grant),
    .pop       (ret),
    .head      (head),
    .empty     (empty)
  );

  assign outstanding = cnt_reg;
  assign err_orphan  = err_reg;

endmodule

// File: tb/tb_offload_arbiter.sv
// Directed-vector bench for offload_arbiter with hand-computed expectations.
module tb_offload_arbiter;
  import offload_pkg::*;

  logic             clk;
  logic             reset_n;
  logic [CNT_W-1:0] outstanding;
  logic             err_orphan;

  int n_checks;
  int n_errs;

  offload_arbiter_if #(
    .NUM_REQ (DEF_NUM_REQ),
    .REQ_W   (DEF_REQ_W),
    .RESP_W  (DEF_RESP_W)
  ) bus ();

  offload_arbiter #(
    .NUM_REQ         (DEF_NUM_REQ),
    .REQ_W           (DEF_REQ_W),
    .RESP_W          (DEF_RESP_W),
    .MAX_OUTSTANDING (DEF_MAX_OUTSTANDING)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  // Compare, count, and print one line per comparison.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("  ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] data_of(input int i);
    return 64'hDA7A_0000_0000_0000 + 64'(i);
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'd1;
    return one << i;
  endfunction

  initial begin
    int     exp_ids[3];
    req_id_t gid;
    n_checks = 0;
    n_errs   = 0;
    clk      = 1'b0;
    reset_n  = 1'b0;
    bus.req_valid      = '0;
    bus.resp_ready     = '0;
    bus.off_req_ready  = 1'b0;
    bus.off_resp_valid = 1'b0;
    bus.off_resp_data  = '0;
    for (int i = 0; i < DEF_NUM_REQ; i++) bus.req_data[i*DEF_REQ_W +: DEF_REQ_W] = data_of(i);

    // ---------------- reset state
    repeat (3) tick();
    bus.req_valid     = 4'b1111;
    bus.off_req_ready = 1'b1;
    #1;
    check_val("rst_off_req_valid", 64'(bus.off_req_valid), 64'd0);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_outstanding", 64'(outstanding), 64'd0);
    check_val("rst_err_orphan", 64'(err_orphan), 64'd0);
    check_val("rst_off_resp_ready", 64'(bus.off_resp_ready), 64'd0);
    check_val("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    bus.req_valid = '0;
    reset_n = 1'b1;
    tick();

    // ---------------- 1: all engines request, accelerator always ready
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k >= 1) begin
        bus.off_resp_valid = 1'b1;
        bus.off_resp_data  = 32'hC0DE_0000 + 32'(k);
      end
      #1;
      check_val($sformatf("t1_req_ready_%0d", k), 64'(bus.req_ready), 64'(oh(k % 4)));
      check_val($sformatf("t1_off_req_data_%0d", k), bus.off_req_data, data_of(k % 4));
      if (k >= 1) begin
        check_val($sformatf("t1_resp_valid_%0d", k), 64'(bus.resp_valid), 64'(oh((k - 1) % 4)));
        check_val($sformatf("t1_resp_data_%0d", k), 64'(bus.resp_data), 64'(32'hC0DE_0000 + 32'(k)));
      end
      tick();
    end
    bus.req_valid = '0;
    #1;
    check_val("t1_outstanding_after", 64'(outstanding), 64'd1);
    check_val("t1_last_resp_valid", 64'(bus.resp_valid), 64'(oh(3)));
    tick();
    bus.off_resp_valid = 1'b0;
    #1;
    check_val("t1_drained", 64'(outstanding), 64'd0);

    // ---------------- 2: engines 1 and 3, accelerator stalls 3 cycles
    bus.req_valid     = 4'b1010;
    bus.off_req_ready = 1'b0;
    #1;
    check_val("t2_off_req_valid", 64'(bus.off_req_valid), 64'd1);
    check_val("t2_stall_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("t2_stall_data_0", bus.off_req_data, data_of(1));
    tick();
    bus.req_valid = 4'b1011;  // engine 0 joins; the locked grant must not move
    #1;
    check_val("t2_stall_data_1", bus.off_req_data, data_of(1));
    tick();
    check_val("t2_stall_data_2", bus.off_req_data, data_of(1));
    check_val("t2_stall_req_ready_2", 64'(bus.req_ready), 64'd0);
    tick();
    bus.off_req_ready = 1'b1;
    #1;
    check_val("t2_accept_1", 64'(bus.req_ready), 64'(oh(1)));
    tick();
    bus.req_valid = 4'b1001;
    #1;
    check_val("t2_then_3", 64'(bus.req_ready), 64'(oh(3)));
    check_val("t2_data_3", bus.off_req_data, data_of(3));
    tick();
    bus.req_valid = 4'b0001;
    #1;
    check_val("t2_then_0", 64'(bus.req_ready), 64'(oh(0)));
    tick();
    bus.req_valid = '0;
    #1;
    check_val("t2_outstanding", 64'(outstanding), 64'd3);
    exp_ids = '{1, 3, 0};
    bus.off_resp_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.off_resp_data = 32'h0000_5000 + 32'(j);
      #1;
      check_val($sformatf("t2_route_%0d", j), 64'(bus.resp_valid), 64'(oh(exp_ids[j])));
      tick();
    end
    bus.off_resp_valid = 1'b0;
    #1;
    check_val("t2_drained", 64'(outstanding), 64'd0);

    // ---------------- 3: no responses, in-flight limit of 4
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val($sformatf("t3_issue_%0d", k), 64'(bus.req_ready), 64'(oh((1 + k) % 4)));
      tick();
    end
    check_val("t3_full_count", 64'(outstanding), 64'd4);
    check_val("t3_full_valid", 64'(bus.off_req_valid), 64'd0);
    check_val("t3_full_ready", 64'(bus.req_ready), 64'd0);
    tick();
    check_val("t3_full_hold", 64'(outstanding), 64'd4);
    bus.off_resp_valid = 1'b1;
    bus.off_resp_data  = 32'h0000_0333;
    #1;
    check_val("t3_ret_head", 64'(bus.resp_valid), 64'(oh(1)));
    check_val("t3_no_bypass", 64'(bus.off_req_valid), 64'd0);
    tick();
    bus.off_resp_valid = 1'b0;
    #1;
    check_val("t3_count_3", 64'(outstanding), 64'd3);
    check_val("t3_reissue_valid", 64'(bus.off_req_valid), 64'd1);
    check_val("t3_reissue_grant", 64'(bus.req_ready), 64'(oh(1)));
    tick();
    check_val("t3_full_again", 64'(outstanding), 64'd4);
    check_val("t3_full_again_valid", 64'(bus.off_req_valid), 64'd0);
    bus.req_valid      = '0;
    bus.off_resp_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check_val($sformatf("t3_drain_%0d", j), 64'(bus.resp_valid), 64'(oh((2 + j) % 4)));
      tick();
    end
    bus.off_resp_valid = 1'b0;
    #1;
    check_val("t3_drained", 64'(outstanding), 64'd0);

    // ---------------- 4: issue 2,0,2 then responses A,B,C with back-pressure
    bus.req_valid = 4'b0100;
    #1;
    check_val("t4_issue_a", 64'(bus.req_ready), 64'(oh(2)));
    tick();
    bus.req_valid = 4'b0001;
    #1;
    check_val("t4_issue_b", 64'(bus.req_ready), 64'(oh(0)));
    tick();
    bus.req_valid = 4'b0100;
    #1;
    check_val("t4_issue_c", 64'(bus.req_ready), 64'(oh(2)));
    tick();
    bus.req_valid      = '0;
    bus.off_resp_valid = 1'b1;
    bus.off_resp_data  = 32'hAAAA_0001;
    #1;
    check_val("t4_a_route", 64'(bus.resp_valid), 64'(oh(2)));
    check_val("t4_a_data", 64'(bus.resp_data), 64'h0000_0000_AAAA_0001);
    check_val("t4_a_ready", 64'(bus.off_resp_ready), 64'd1);
    tick();
    bus.off_resp_data = 32'hBBBB_0002;
    bus.resp_ready    = 4'b1110;
    #1;
    check_val("t4_b_route", 64'(bus.resp_valid), 64'(oh(0)));
    check_val("t4_b_stall", 64'(bus.off_resp_ready), 64'd0);
    tick();
    check_val("t4_b_stall_count", 64'(outstanding), 64'd2);
    check_val("t4_b_stall_ready", 64'(bus.off_resp_ready), 64'd0);
    tick();
    bus.resp_ready = 4'b1111;
    #1;
    check_val("t4_b_release", 64'(bus.off_resp_ready), 64'd1);
    tick();
    bus.off_resp_data = 32'hCCCC_0003;
    #1;
    check_val("t4_c_route", 64'(bus.resp_valid), 64'(oh(2)));
    check_val("t4_c_data", 64'(bus.resp_data), 64'h0000_0000_CCCC_0003);
    tick();
    bus.off_resp_valid = 1'b0;
    #1;
    check_val("t4_drained", 64'(outstanding), 64'd0);

    // ---------------- 5: orphan response after reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus.off_resp_valid = 1'b1;
    bus.off_resp_data  = 32'hDEAD_0005;
    #1;
    check_val("t5_orphan_ready", 64'(bus.off_resp_ready), 64'd1);
    check_val("t5_orphan_no_resp", 64'(bus.resp_valid), 64'd0);
    check_val("t5_err_before", 64'(err_orphan), 64'd0);
    tick();
    bus.off_resp_valid = 1'b0;
    #1;
    check_val("t5_err_set", 64'(err_orphan), 64'd1);
    tick();
    tick();
    check_val("t5_err_sticky", 64'(err_orphan), 64'd1);
    check_val("t5_count", 64'(outstanding), 64'd0);

    // ---------------- 6: reset mid-burst with 3 in flight
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      gid = req_id_t'(k);
      check_val($sformatf("t6_issue_%0d", k), 64'(bus.req_ready), 64'(oh(int'(gid))));
      tick();
    end
    check_val("t6_in_flight", 64'(outstanding), 64'd3);
    reset_n = 1'b0;
    #1;
    check_val("t6_async_valid", 64'(bus.off_req_valid), 64'd0);
    check_val("t6_async_ready", 64'(bus.req_ready), 64'd0);
    check_val("t6_async_count", 64'(outstanding), 64'd0);
    check_val("t6_async_err", 64'(err_orphan), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_val("t6_first_winner", 64'(bus.req_ready), 64'(oh(0)));
    check_val("t6_first_data", bus.off_req_data, data_of(0));
    check_val("t6_count_after", 64'(outstanding), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
